gmii_rx_align: RTL and testbench
================================

Name: gmii_rx_align

Overview:
- Front-end receive stage between the GMII pins (already in the clk domain) and the ID filter stage.
- Strips preamble and SFD, and optionally strips the 4-byte FCS.
- Drops malformed frames.
- Emits a contiguous, byte-aligned frame as rxdata/rx_en, where byte 0 is the first destination-MAC byte. The ID filter's fixed offsets (ID byte at 0x22) depend on this alignment.

Parameters:
- MIN_PRE, 1: minimum count of 0x55 bytes required before the SFD.
- MAX_LEN, 1518: maximum number of bytes after the SFD, including FCS; longer frames are aborted.
- MIN_LEN, 64: minimum number of bytes after the SFD, including FCS, for a frame to count as good.
- STRIP_FCS, 1: 1 discards the last 4 bytes of each frame; 0 passes them through.

Ports:
- clk, input, 1: 125 MHz GMII receive clock; the only clock.
- rst, input, 1: asynchronous, active-high reset.
- gmii_rx_dv, input, 1: GMII data valid.
- gmii_rx_er, input, 1: GMII receive error.
- gmii_rxd, input, 8: GMII receive data.
- rx_en, output, 1: aligned frame byte valid; continuous for the whole frame.
- rxdata, output, 8: aligned frame byte.
- frame_ok, output, 1: one-cycle pulse when a frame ends cleanly.
- frame_err, output, 1: one-cycle pulse when a frame is aborted or runt.

Behaviour:
- Reset: outputs, FSM, counters and delay line are cleared asynchronously.
  - rx_en=0, rxdata=0, frame_ok=0, frame_err=0, state=IDLE.
  - Deasserting rst mid-frame leaves the FSM in IDLE. It needs dv=0 before it will lock onto a new frame, so a partial frame is never emitted.
- Input stage: gmii_* are registered once (dv_r, er_r, d_r). The FSM acts on the registered values.
- Byte counter cnt (11 bits):
  - cleared on the SFD;
  - increments for each DATA byte;
  - saturates at MAX_LEN and never wraps.
- Preamble counter pcnt: 4 bits, saturating.
- State IDLE:
  - dv_r=1 and d_r=0x55: go to PRE, pcnt=1.
  - dv_r=1 and any other byte: go to DROP. No error pulse, since it is a false carrier.
- State PRE:
  - dv_r=1, d_r=0x55: pcnt++.
  - dv_r=1, d_r=0xD5, pcnt>=MIN_PRE: go to DATA, cnt=0.
  - dv_r=1, any other byte: go to DROP, no pulse.
  - dv_r=0: go to IDLE.
- State DATA, evaluated in this priority:
  1. er_r=1: go to DROP, pulse frame_err.
  2. dv_r=1 and cnt==MAX_LEN: go to DROP, pulse frame_err.
  3. dv_r=0 and cnt>=MIN_LEN: go to IDLE, pulse frame_ok.
  4. dv_r=0 and cnt<MIN_LEN: go to IDLE, pulse frame_err.
- State DROP:
  - wait for dv_r=0, then go to IDLE;
  - nothing is emitted.
- Output path, STRIP_FCS=0:
  - each DATA byte is registered to rxdata with rx_en=1;
  - latency is 2 clk from gmii_rxd to rxdata.
- Output path, STRIP_FCS=1:
  - DATA bytes pass through a 4-entry shift register with a fill count of 0..4;
  - a byte is emitted only when a new DATA byte arrives with fill==4;
  - latency is 6 clk; the 4 bytes left at end of frame are discarded;
  - a frame of 4 or fewer bytes after the SFD produces no rx_en at all.
- Abort (entry to DROP from DATA):
  - rx_en falls on the next cycle and the delay line is flushed;
  - the downstream stage sees a truncated frame followed by the frame_err pulse.
- rx_en rules:
  - rx_en is 0 for at least 1 cycle between frames;
  - a new frame's SFD arriving 1 cycle after dv drops must still be accepted (minimum IPG handling);
  - rx_en never has gaps within a frame.
- Pulse timing: frame_ok and frame_err are asserted in the cycle after the transition that causes them. They are mutually exclusive and only one fires per frame.
- gmii_rx_er outside DATA is ignored.

Test Plan:
- 7×0x55, 0xD5, 64 bytes 0x00..0x3F, dv=1 throughout, STRIP_FCS=1 -> rx_en high exactly 60 cycles, rxdata 0x00..0x3B, first byte 6 clk after the input 0x00, one frame_ok pulse.
- Same frame with STRIP_FCS=0 -> 64 bytes 0x00..0x3F, latency 2 clk, frame_ok.
- er asserted on payload byte 20 -> rx_en falls 1 cycle later, frame_err pulses once, no frame_ok, remaining bytes dropped until dv=0.
- 1600-byte frame with MAX_LEN=1518 -> exactly 1514 bytes emitted, frame_err, DROP until dv=0; the next good frame is received normally.
- Bad preamble sequence 0x55,0x55,0x5D,0xD5,… -> no rx_en, no pulses. A 30-byte runt -> 26 bytes emitted (STRIP_FCS=1), then frame_err.
- Two 64-byte frames with 1-cycle dv gap; also rst pulsed during byte 10 of a frame -> back-to-back frames both give frame_ok; the reset case gives outputs 0 immediately, no output until the following frame, which is received cleanly.

Source files
------------

// File: rtl/gmii_rx_align_if.sv
// GMII receive pins and the byte-aligned frame stream handed to the ID filter.
interface gmii_rx_align_if;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] gmii_rxd;
    logic       rx_en;
    logic [7:0] rxdata;
    logic       frame_ok;
    logic       frame_err;

    // master: PHY side driving the pins and consuming the aligned stream
    modport master (
        output gmii_rx_dv, gmii_rx_er, gmii_rxd,
        input  rx_en, rxdata, frame_ok, frame_err
    );
    modport slave (
        input  gmii_rx_dv, gmii_rx_er, gmii_rxd,
        output rx_en, rxdata, frame_ok, frame_err
    );
endinterface

// File: rtl/gmii_rx_align.sv
// GMII receive front end: strips preamble/SFD (and optionally FCS), drops malformed
// frames and emits a contiguous byte stream whose byte 0 is the first DA byte.
module gmii_rx_align #(
    parameter int unsigned MIN_PRE   = 1,
    parameter int unsigned MAX_LEN   = 1518,
    parameter int unsigned MIN_LEN   = 64,
    parameter bit          STRIP_FCS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    gmii_rx_align_if.slave  bus
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_PRE    = 2'd1;
    localparam logic [1:0]  ST_DATA   = 2'd2;
    localparam logic [1:0]  ST_DROP   = 2'd3;
    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
    localparam logic [3:0]  MIN_PRE_C = 4'(MIN_PRE);

    logic            dv_q, er_q, in_vld_q;
    logic [7:0]      d_q;
    logic            armed_q, armed_d;
    logic [1:0]      state_q, state_d;
    logic [10:0]     cnt_q, cnt_d;
    logic [3:0]      pcnt_q, pcnt_d;
    logic [3:0][7:0] line_q, line_d;
    logic [2:0]      fill_q, fill_d;
    logic            rx_en_q, rx_en_d;
    logic [7:0]      rxdata_q, rxdata_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic            byte_s;

    // Input stage: the FSM only ever looks at these registered copies of the pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q     <= 1'b0;
            er_q     <= 1'b0;
            d_q      <= 8'h00;
            in_vld_q <= 1'b0;
        end else begin
            dv_q     <= bus.gmii_rx_dv;
            er_q     <= bus.gmii_rx_er;
            d_q      <= bus.gmii_rxd;
            in_vld_q <= 1'b1;
        end
    end

    // Frame FSM, byte counters, FCS delay line and registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pcnt_d      = pcnt_q;
        line_d      = line_q;
        fill_d      = fill_q;
        rx_en_d     = 1'b0;
        rxdata_d    = 8'h00;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        byte_s      = 1'b0;
        // armed only after a real dv=0 sample, so a frame cut by reset is never picked up mid-way
        armed_d     = armed_q | (in_vld_q & ~dv_q);

        case (state_q)
            ST_IDLE: begin
                if (dv_q) begin
                    if (armed_q && (d_q == PRE_BYTE)) begin
                        state_d = ST_PRE;
                        pcnt_d  = 4'd1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end else if (d_q == PRE_BYTE) begin
                    if (pcnt_q != 4'hF) begin
                        pcnt_d = pcnt_q + 4'd1;
                    end else begin
                        pcnt_d = pcnt_q;
                    end
                end else if ((d_q == SFD_BYTE) && (pcnt_q >= MIN_PRE_C)) begin
                    state_d = ST_DATA;
                    cnt_d   = 11'd0;
                    fill_d  = 3'd0;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (er_q || (dv_q && (cnt_q == MAX_LEN_C))) begin
                    state_d     = ST_DROP;
                    frame_err_d = 1'b1;
                    fill_d      = 3'd0;
                end else if (dv_q) begin
                    byte_s = 1'b1;
                    cnt_d  = cnt_q + 11'd1;
                end else begin
                    state_d     = ST_IDLE;
                    frame_ok_d  = (cnt_q >= MIN_LEN_C);
                    frame_err_d = (cnt_q <  MIN_LEN_C);
                    fill_d      = 3'd0;
                end
            end
            ST_DROP: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (byte_s) begin
            if (STRIP_FCS) begin
                // line_q[3] holds the oldest byte; it leaves only once four newer bytes exist
                line_d = {line_q[2:0], d_q};
                if (fill_q == 3'd4) begin
                    rx_en_d  = 1'b1;
                    rxdata_d = line_q[3];
                end else begin
                    fill_d = fill_q + 3'd1;
                end
            end else begin
                rx_en_d  = 1'b1;
                rxdata_d = d_q;
            end
        end else begin
            rx_en_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= 11'd0;
            pcnt_q      <= 4'd0;
            line_q      <= 32'h0000_0000;
            fill_q      <= 3'd0;
            rx_en_q     <= 1'b0;
            rxdata_q    <= 8'h00;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pcnt_q      <= pcnt_d;
            line_q      <= line_d;
            fill_q      <= fill_d;
            rx_en_q     <= rx_en_d;
            rxdata_q    <= rxdata_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.rx_en     = rx_en_q;
    assign bus.rxdata    = rxdata_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_gmii_rx_align.sv
// Drives one GMII stream into a FCS-stripping and a pass-through aligner and
// checks both against a frame-level reference model.
module tb_gmii_rx_align;
    localparam int MIN_PRE = 1;
    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dv  = 1'b0;
    logic       er  = 1'b0;
    logic [7:0] rxd = 8'h00;

    gmii_rx_align_if sif ();
    gmii_rx_align_if pif ();

    assign sif.gmii_rx_dv = dv;
    assign sif.gmii_rx_er = er;
    assign sif.gmii_rxd   = rxd;
    assign pif.gmii_rx_dv = dv;
    assign pif.gmii_rx_er = er;
    assign pif.gmii_rxd   = rxd;

    gmii_rx_align #(.MIN_PRE(MIN_PRE), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .STRIP_FCS(1'b1))
        u_strip (.clk(clk), .rst(rst), .bus(sif.slave));
    gmii_rx_align #(.MIN_PRE(MIN_PRE), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .STRIP_FCS(1'b0))
        u_pass  (.clk(clk), .rst(rst), .bus(pif.slave));

    always #4 clk = ~clk;

    typedef struct {
        logic       dv;
        logic       er;
        logic [7:0] d;
    } cyc_t;

    cyc_t stim_q[$];
    int   exp_s[$], exp_p[$], exp_pul[$];
    int   exp_runs_s, exp_runs_p;
    int   obs_s[$], obs_p[$], pul_s[$], pul_p[$];
    time  ts_s[$], ts_p[$], pt_s[$], pt_p[$];
    int   mark_idx;
    time  mark_t;
    int   n_pass  = 0;
    int   n_total = 0;

    // Record every emitted byte and every pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (sif.rx_en) begin obs_s.push_back(int'(sif.rxdata)); ts_s.push_back($time); end
            if (pif.rx_en) begin obs_p.push_back(int'(pif.rxdata)); ts_p.push_back($time); end
            if (sif.frame_ok || sif.frame_err) begin
                pul_s.push_back(int'({sif.frame_err, sif.frame_ok})); pt_s.push_back($time);
            end
            if (pif.frame_ok || pif.frame_err) begin
                pul_p.push_back(int'({pif.frame_err, pif.frame_ok})); pt_p.push_back($time);
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    function automatic int first_diff(input int a[$], input int b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    // number of contiguous rx_en bursts
    function automatic int runs(input time q[$]);
        int n;
        n = 0;
        for (int i = 0; i < q.size(); i++) if ((i == 0) || (q[i] - q[i-1] != 8)) n++;
        return n;
    endfunction

    task automatic push(input logic v, input logic e, input logic [7:0] b);
        cyc_t c;
        c.dv = v; c.er = e; c.d = b;
        stim_q.push_back(c);
    endtask

    // base < 0 gives random payload, otherwise an incrementing pattern from base
    task automatic add_frame(input int pre, input logic [7:0] sfd, input int len,
                             input int er_at, input int base, input int gap);
        for (int i = 0; i < pre; i++) push(1'b1, ($urandom_range(0, 7) == 0), 8'h55);
        push(1'b1, 1'b0, sfd);
        for (int j = 0; j < len; j++)
            push(1'b1, (j == er_at), (base < 0) ? 8'($urandom) : 8'(base + j));
        for (int g = 0; g < gap; g++) push(1'b0, 1'b0, 8'h00);
    endtask

    // Frame-level reference: one dv burst is one candidate frame
    task automatic eval_run(input int s, input int e);
        int k, p, acc, code;
        k = s; p = 0;
        while ((k < e) && (stim_q[k].d == 8'h55)) begin p++; k++; end
        if ((p > 0) && (k < e) && (stim_q[k].d == 8'hD5) && (p >= MIN_PRE)) begin
            k++; acc = 0; code = 0;
            for (int j = k; j < e; j++) begin
                if (stim_q[j].er || (acc == MAX_LEN)) begin code = 2; break; end
                acc++;
            end
            if (code == 0) code = (acc >= MIN_LEN) ? 1 : 2;
            exp_pul.push_back(code);
            for (int j = 0; j < acc; j++) begin
                exp_p.push_back(int'(stim_q[k+j].d));
                if (j < acc - 4) exp_s.push_back(int'(stim_q[k+j].d));
            end
            if (acc > 0) exp_runs_p++;
            if (acc > 4) exp_runs_s++;
        end
    endtask

    task automatic model(input bit armed0);
        int  i, n, s;
        bit  armed;
        exp_s.delete(); exp_p.delete(); exp_pul.delete();
        exp_runs_s = 0; exp_runs_p = 0;
        i = 0; n = stim_q.size(); armed = armed0;
        while (i < n) begin
            if (!stim_q[i].dv) begin
                armed = 1'b1; i++;
            end else begin
                s = i;
                while ((i < n) && stim_q[i].dv) i++;
                if (armed) eval_run(s, i);
            end
        end
    endtask

    task automatic clear_obs();
        obs_s.delete(); obs_p.delete(); pul_s.delete(); pul_p.delete();
        ts_s.delete(); ts_p.delete(); pt_s.delete(); pt_p.delete();
    endtask

    task automatic play(input int drain);
        for (int i = 0; i < stim_q.size(); i++) begin
            @(negedge clk);
            dv = stim_q[i].dv; er = stim_q[i].er; rxd = stim_q[i].d;
            if (i == mark_idx) mark_t = $time;
        end
        for (int i = 0; i < drain; i++) begin
            @(negedge clk);
            dv = 1'b0; er = 1'b0; rxd = 8'h00;
        end
    endtask

    task automatic evaluate(input string tag);
        chk({tag, ".s_len"},   obs_s.size(), exp_s.size());
        chk({tag, ".s_data"},  first_diff(obs_s, exp_s), -1);
        chk({tag, ".s_runs"},  runs(ts_s), exp_runs_s);
        chk({tag, ".s_pulse"}, first_diff(pul_s, exp_pul), -1);
        chk({tag, ".p_len"},   obs_p.size(), exp_p.size());
        chk({tag, ".p_data"},  first_diff(obs_p, exp_p), -1);
        chk({tag, ".p_runs"},  runs(ts_p), exp_runs_p);
        chk({tag, ".p_pulse"}, first_diff(pul_p, exp_pul), -1);
    endtask

    task automatic run_scn(input string tag, input bit armed0);
        @(posedge clk);
        #1;
        clear_obs();
        model(armed0);
        play(16);
        evaluate(tag);
    endtask

    initial begin
        mark_idx = -1;
        mark_t   = 0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.s", int'({sif.rx_en, sif.rxdata, sif.frame_ok, sif.frame_err}), 0);
        chk("reset.p", int'({pif.rx_en, pif.rxdata, pif.frame_ok, pif.frame_err}), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 64-byte frame 0x00..0x3F behind a 7-byte preamble
        stim_q.delete(); add_frame(7, 8'hD5, 64, -1, 0, 2); mark_idx = 8;
        run_scn("good64", 1'b1);
        chk("good64.s_count", obs_s.size(), 60);
        chk("good64.s_last",  (obs_s.size() == 60) ? obs_s[59] : -1, 8'h3B);
        chk("good64.s_lat",   (ts_s.size() > 0) ? int'(ts_s[0] - mark_t) : -1, 48);
        chk("good64.p_lat",   (ts_p.size() > 0) ? int'(ts_p[0] - mark_t) : -1, 16);
        chk("good64.ok",      (pul_s.size() == 1) ? pul_s[0] : -1, 1);

        // receive error on payload byte 20
        stim_q.delete(); add_frame(7, 8'hD5, 64, 20, 0, 2); mark_idx = 28;
        run_scn("er20", 1'b1);
        chk("er20.s_count",  obs_s.size(), 16);
        chk("er20.p_count",  obs_p.size(), 20);
        chk("er20.p_fall",   (ts_p.size() > 0) ? int'(ts_p[ts_p.size()-1] - mark_t) : -1, 8);
        chk("er20.err_time", (pt_p.size() > 0) ? int'(pt_p[0] - mark_t) : -1, 16);
        chk("er20.err",      (pul_p.size() == 1) ? pul_p[0] : -1, 2);
        mark_idx = -1;

        // oversize frame followed by a good one
        stim_q.delete(); add_frame(7, 8'hD5, 1600, -1, -1, 2); add_frame(7, 8'hD5, 64, -1, 0, 2);
        run_scn("giant", 1'b1);
        chk("giant.s_count", obs_s.size(), 1514 + 60);
        chk("giant.p_count", obs_p.size(), 1518 + 64);

        // corrupted preamble then a 30-byte runt
        stim_q.delete();
        push(1'b1, 1'b0, 8'h55); push(1'b1, 1'b0, 8'h55); push(1'b1, 1'b0, 8'h5D); push(1'b1, 1'b0, 8'hD5);
        for (int j = 0; j < 20; j++) push(1'b1, 1'b0, 8'($urandom));
        push(1'b0, 1'b0, 8'h00); push(1'b0, 1'b0, 8'h00);
        add_frame(7, 8'hD5, 30, -1, -1, 2);
        run_scn("badpre_runt", 1'b1);
        chk("badpre_runt.s_count", obs_s.size(), 26);
        chk("badpre_runt.pulses",  pul_s.size(), 1);

        // back-to-back frames with a single idle cycle
        stim_q.delete(); add_frame(7, 8'hD5, 64, -1, 0, 1); add_frame(7, 8'hD5, 64, -1, 64, 1);
        run_scn("b2b", 1'b1);
        chk("b2b.p_count", obs_p.size(), 128);

        // reset pulsed during payload byte 10
        stim_q.delete(); add_frame(7, 8'hD5, 11, -1, 128, 0); mark_idx = -1;
        play(0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.s", int'({sif.rx_en, sif.rxdata, sif.frame_ok, sif.frame_err}), 0);
        chk("rst_mid.p", int'({pif.rx_en, pif.rxdata, pif.frame_ok, pif.frame_err}), 0);
        @(negedge clk);
        rst = 1'b0;
        stim_q.delete();
        for (int j = 0; j < 40; j++) push(1'b1, 1'b0, 8'(139 + j));
        push(1'b0, 1'b0, 8'h00);
        add_frame(7, 8'hD5, 64, -1, 0, 2);
        run_scn("after_rst", 1'b0);
        chk("after_rst.p_count", obs_p.size(), 64);

        // randomized frame mix: false carrier, bad SFD, runts, tiny frames, errors
        for (int r = 0; r < 3; r++) begin
            stim_q.delete();
            for (int f = 0; f < 16; f++) begin
                int len;
                len = $urandom_range(0, 90);
                add_frame($urandom_range(0, 8),
                          ($urandom_range(0, 7) == 0) ? 8'h5A : 8'hD5,
                          len,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1,
                          -1,
                          $urandom_range(1, 3));
            end
            run_scn($sformatf("rand%0d", r), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
